fma_share_arbiter: RTL and testbench

Round-robin controller that shares one pipelined `fma_wrapper` instance (fixed `FMADD`, RNE) between `NREQ` requesters. It:
- arbitrates one multiply-add issue per cycle;
- tracks each in-flight operation's requester ID through a shift register that matches the FMA latency;
- returns results with valid/ready backpressure, stalling the FMA through its pipeline-enable input;
- optionally drives the FMA zero-gating mux select.

It sits between the systolic-array-side control logic and a single shared FMA datapath.

---
 rtl/fma_share_arbiter.sv | 116 +++++++++++
 tb/tb_fma_share_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fma_share_arbiter.sv
// fma_share_arbiter
//   Round-robin controller sharing one pipelined FMA between NREQ requesters.
//   Each cycle it grants at most one requester, muxes that requester's
//   operands onto the FMA, and tracks the requester ID down a LAT-deep shift
//   register aligned with the FMA pipeline. Results return via valid/ready;
//   an unaccepted response freezes the FMA (pipeline enable) and the tracker.
//
//   Optional feature macro: FMA_ARB_ZERO_GATE_EN
//     defined   : o_fma_msel = 1 when the issued a or b is +/-0 (product bypass)
//     undefined : o_fma_msel tied to 0
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req / o_gnt           per-requester request, one-hot grant
//   i_a, i_b, i_c           packed per-requester operands, requester k at [k*FP_W +: FP_W]
//   o_fma_a/b/c, o_fma_msel operands and mux select driven to the FMA
//   o_fma_pipeline_en       FMA pipeline enable (low while a response is held)
//   i_fma_c                 FMA result
//   o_rsp_valid/id/data     response channel, i_rsp_ready consumer ready
//   o_busy                  at least one operation in flight
module fma_share_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned FP_W = 16,
  parameter int unsigned LAT  = 2,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NREQ-1:0]        i_req,
  output logic [NREQ-1:0]        o_gnt,
  input  logic [NREQ*FP_W-1:0]   i_a,
  input  logic [NREQ*FP_W-1:0]   i_b,
  input  logic [NREQ*FP_W-1:0]   i_c,
  output logic [FP_W-1:0]        o_fma_a,
  output logic [FP_W-1:0]        o_fma_b,
  output logic [FP_W-1:0]        o_fma_c,
  output logic                   o_fma_msel,
  output logic                   o_fma_pipeline_en,
  input  logic [FP_W-1:0]        i_fma_c,
  output logic                   o_rsp_valid,
  output logic [IDW-1:0]         o_rsp_id,
  output logic [FP_W-1:0]        o_rsp_data,
  input  logic                   i_rsp_ready,
  output logic                   o_busy
);

  logic [IDW-1:0] rr;
  logic [LAT-1:0] vld;
  logic [IDW-1:0] id [LAT];

  logic           stall;
  logic           hit;
  logic [IDW-1:0] sel;
  int unsigned    idx;

  always_comb stall = vld[LAT-1] & ~i_rsp_ready;

  // First asserted request at or after rr, wrapping modulo NREQ.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    idx = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = (32'(rr) + off) % NREQ;
      if (!stall && !hit && i_req[idx]) begin
        hit = 1'b1;
        sel = IDW'(idx);
      end
    end
  end

  always_comb begin
    o_gnt   = '0;
    o_fma_a = '0;
    o_fma_b = '0;
    o_fma_c = '0;
    if (hit) begin
      o_gnt[sel] = 1'b1;
      o_fma_a    = i_a[sel*FP_W +: FP_W];
      o_fma_b    = i_b[sel*FP_W +: FP_W];
      o_fma_c    = i_c[sel*FP_W +: FP_W];
    end
  end

`ifdef FMA_ARB_ZERO_GATE_EN
  always_comb o_fma_msel = hit & ((o_fma_a[FP_W-2:0] == '0) | (o_fma_b[FP_W-2:0] == '0));
`else
  always_comb o_fma_msel = 1'b0;
`endif

  always_comb begin
    o_fma_pipeline_en = ~stall;
    o_rsp_valid       = vld[LAT-1];
    o_rsp_id          = id[LAT-1];
    o_rsp_data        = i_fma_c;
    o_busy            = |vld;
  end

  // Tracker advances only with the FMA; empty cycles shift in as bubbles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr  <= '0;
      vld <= '0;
    end else if (!stall) begin
      vld[0] <= hit;
      id[0]  <= sel;
      for (int unsigned i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
        id[i]  <= id[i-1];
      end
      if (hit)
        rr <= (sel == IDW'(NREQ-1)) ? '0 : sel + 1'b1;
    end
  end

endmodule

// File: tb/tb_fma_share_arbiter.sv
// Self-checking bench for fma_share_arbiter. A simple integer stand-in for
// the FMA (LAT-stage pipeline honouring the enable) supplies results; the
// reference model tracks outstanding operations as a queue ordered by issue,
// each due LAT unstalled cycles after issue.
module tb_fma_share_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned FP_W = 16;
  localparam int unsigned LAT  = 2;
  localparam int unsigned IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      gnt;
  logic [NREQ*FP_W-1:0] a_bus, b_bus, c_bus;
  logic [FP_W-1:0]      fma_a, fma_b, fma_c, fma_res;
  logic                 fma_msel, fma_en;
  logic                 rsp_valid, rsp_ready, busy;
  logic [IDW-1:0]       rsp_id;
  logic [FP_W-1:0]      rsp_data;

  always #5 clk = ~clk;

  fma_share_arbiter #(.NREQ(NREQ), .FP_W(FP_W), .LAT(LAT), .IDW(IDW)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .o_gnt(gnt),
    .i_a(a_bus), .i_b(b_bus), .i_c(c_bus),
    .o_fma_a(fma_a), .o_fma_b(fma_b), .o_fma_c(fma_c),
    .o_fma_msel(fma_msel), .o_fma_pipeline_en(fma_en),
    .i_fma_c(fma_res),
    .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_data(rsp_data),
    .i_rsp_ready(rsp_ready), .o_busy(busy)
  );

  function automatic logic [FP_W-1:0] fake_fma(input logic [FP_W-1:0] x, y, z, input logic m);
    return m ? z : FP_W'(x * y + z + 16'h1357);
  endfunction

  // FMA stand-in: result emerges LAT enabled cycles after the operands.
  logic [FP_W-1:0] pipe [LAT];
  always @(posedge clk) begin
    if (fma_en) begin
      pipe[0] <= fake_fma(fma_a, fma_b, fma_c, fma_msel);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign fma_res = pipe[LAT-1];

  typedef struct {
    int unsigned     id;
    logic [FP_W-1:0] data;
    int unsigned     due;
  } ent_t;

  ent_t        q[$];
  int unsigned m_rr;
  int unsigned adv;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;

  logic [FP_W-1:0] op_a [NREQ];
  logic [FP_W-1:0] op_b [NREQ];
  logic [FP_W-1:0] op_c [NREQ];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [FP_W-1:0] rnd_op();
    logic [FP_W-1:0] v;
    v = FP_W'($urandom);
    if ($urandom_range(0, 5) == 0) v = {v[FP_W-1], {(FP_W-1){1'b0}}};
    return v;
  endfunction

  // One clock: drive at negedge, check combinational outputs, advance model at posedge.
  task automatic step(input logic [NREQ-1:0] r, input logic rdy, input logic rs, input bit rnd);
    bit              exp_valid, exp_stall, g_hit, exp_msel;
    int unsigned     k;
    logic [NREQ-1:0] exp_gnt;
    logic [FP_W-1:0] ea, eb, ec;
    @(negedge clk);
    if (rnd)
      for (int i = 0; i < NREQ; i++) begin
        op_a[i] = rnd_op(); op_b[i] = rnd_op(); op_c[i] = FP_W'($urandom);
      end
    for (int i = 0; i < NREQ; i++) begin
      a_bus[i*FP_W +: FP_W] = op_a[i];
      b_bus[i*FP_W +: FP_W] = op_b[i];
      c_bus[i*FP_W +: FP_W] = op_c[i];
    end
    req = r; rsp_ready = rdy; rst = rs;
    #1;
    exp_valid = (q.size() > 0) && (q[0].due == adv);
    exp_stall = exp_valid && !rdy;
    g_hit = 0; k = 0;
    if (!exp_stall)
      for (int off = 0; off < NREQ; off++)
        if (!g_hit && r[(m_rr + off) % NREQ]) begin
          g_hit = 1; k = (m_rr + off) % NREQ;
        end
    exp_gnt = '0;
    ea = '0; eb = '0; ec = '0;
    if (g_hit) begin
      exp_gnt[k] = 1'b1;
      ea = op_a[k]; eb = op_b[k]; ec = op_c[k];
    end
`ifdef FMA_ARB_ZERO_GATE_EN
    exp_msel = g_hit && ((ea[FP_W-2:0] == '0) || (eb[FP_W-2:0] == '0));
`else
    exp_msel = 0;
`endif
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("fma_a", 32'(fma_a), 32'(ea));
    check("fma_b", 32'(fma_b), 32'(eb));
    check("fma_c", 32'(fma_c), 32'(ec));
    check("msel", 32'(fma_msel), 32'(exp_msel));
    check("pipe_en", 32'(fma_en), 32'(!exp_stall));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    check("busy", 32'(busy), 32'(q.size() > 0));
    if (exp_valid) begin
      check("rsp_id", 32'(rsp_id), q[0].id);
      check("rsp_data", 32'(rsp_data), 32'(q[0].data));
    end
    @(posedge clk);
    cyc++;
    if (rs) begin
      q.delete();
      m_rr = 0;
    end else if (!exp_stall) begin
      if (exp_valid) void'(q.pop_front());
      if (g_hit) begin
        q.push_back('{id: k, data: fake_fma(ea, eb, ec, exp_msel), due: adv + LAT});
        m_rr = (k + 1) % NREQ;
      end
      adv++;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < int'(LAT) + 2; i++) step('0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    req = '0; rst = 1'b1; rsp_ready = 1'b1;
    a_bus = '0; b_bus = '0; c_bus = '0;
    for (int i = 0; i < NREQ; i++) begin op_a[i] = '0; op_b[i] = '0; op_c[i] = '0; end
    repeat (3) @(negedge clk);
    q.delete(); m_rr = 0; adv = 0;

    // Reset state and single issue from requester 0.
    step('0, 1'b1, 1'b1, 1'b1);
    op_a[0] = 16'h4000; op_b[0] = 16'h4200; op_c[0] = 16'h3C00;
    step(4'b0001, 1'b1, 1'b0, 1'b0);
    drain();

    // Fairness: all requesting for eight cycles.
    for (int i = 0; i < 8; i++) step(4'b1111, 1'b1, 1'b0, 1'b1);
    drain();

    // Backpressure: response held for three cycles.
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b0, 1'b1);
    drain();

    // Wrap-around: move rr to 2 via requester 1, then only 3 and 1 request.
    step(4'b0010, 1'b1, 1'b0, 1'b1);
    drain();
    for (int i = 0; i < 3; i++) step(4'b1010, 1'b1, 1'b0, 1'b1);
    drain();

    // Zero operand on requester 2.
    op_a[2] = 16'h8000; op_b[2] = 16'h4000; op_c[2] = 16'h3C00;
    step(4'b0100, 1'b1, 1'b0, 1'b0);
    drain();

    // Reset with two operations in flight.
    step(4'b1111, 1'b1, 1'b0, 1'b1);
    step(4'b1111, 1'b1, 1'b0, 1'b1);
    step('0, 1'b1, 1'b1, 1'b1);
    drain();

    // Randomized traffic with backpressure and occasional reset.
    for (int i = 0; i < 3000; i++)
      step(NREQ'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 199) == 0), 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
